// File: rtl/enemy_bullet_ctrl.sv
// rtl/enemy_bullet_ctrl.sv - single enemy bullet: fire, fall, hit test, cooldown (optional ENEMY_BULLET_LFSR_EN fire gating)
module enemy_bullet_ctrl #(
  parameter int V_BOTTOM   = 479,
  parameter int STEP       = 2,
  parameter int PLANE_W    = 32,
  parameter int PLANE_H    = 16,
  parameter int COOL_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic [9:0] h_enemy,
  input  logic [9:0] v_enemy,
  input  logic       enemy_valid,
  input  logic [9:0] h_my_plane,
  input  logic [9:0] v_my_plane,
  output logic [9:0] h_bullet,
  output logic [9:0] v_bullet,
  output logic       active,
  output logic       hit
);

  localparam int CW = $clog2(COOL_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

  state_t        state;
  logic [CW-1:0] cool_cnt;
  logic          fire_ok;

`ifdef ENEMY_BULLET_LFSR_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11); gates firing to ~1 in 16 ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign fire_ok = (lfsr[3:0] == 4'h0);
`else
  assign fire_ok = 1'b1;
`endif

  // Hitbox and bottom limits are evaluated 11 bits wide so they never wrap
  logic [10:0] h_lo, h_hi, v_lo, v_hi, v_next;
  logic        in_box, past_bottom;

  assign h_lo        = {1'b0, h_my_plane};
  assign h_hi        = h_lo + 11'(PLANE_W - 1);
  assign v_lo        = {1'b0, v_my_plane};
  assign v_hi        = v_lo + 11'(PLANE_H - 1);
  assign in_box      = ({1'b0, h_bullet} >= h_lo) && ({1'b0, h_bullet} <= h_hi) &&
                       ({1'b0, v_bullet} >= v_lo) && ({1'b0, v_bullet} <= v_hi);
  assign v_next      = {1'b0, v_bullet} + 11'(STEP);
  assign past_bottom = v_next > 11'(V_BOTTOM);

  // Bullet state machine; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      h_bullet <= 10'd0;
      v_bullet <= 10'd0;
      active   <= 1'b0;
      hit      <= 1'b0;
      cool_cnt <= '0;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          h_bullet <= h_enemy;
          v_bullet <= v_enemy;
          active   <= 1'b0;
          if (move_tick && enemy_valid && fire_ok) begin
            state  <= FLY;
            active <= 1'b1;
          end
        end
        FLY: begin
          // A hit takes priority over reaching the bottom on the same cycle
          if (in_box) begin
            hit      <= 1'b1;
            state    <= COOLDOWN;
            active   <= 1'b0;
            cool_cnt <= '0;
          end else if (move_tick) begin
            if (past_bottom) begin
              state    <= COOLDOWN;
              active   <= 1'b0;
              cool_cnt <= '0;
            end else begin
              v_bullet <= v_next[9:0];
            end
          end
        end
        COOLDOWN: begin
          h_bullet <= h_enemy;
          v_bullet <= v_enemy;
          active   <= 1'b0;
          if (move_tick) begin
            if (cool_cnt == CW'(COOL_TICKS - 1)) begin
              state    <= IDLE;
              cool_cnt <= '0;
            end else begin
              cool_cnt <= cool_cnt + CW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// tb/tb_enemy_bullet_ctrl.sv - self-checking bench for enemy_bullet_ctrl
module tb_enemy_bullet_ctrl;

  localparam int V_BOTTOM   = 479;
  localparam int STEP       = 2;
  localparam int PLANE_W    = 32;
  localparam int PLANE_H    = 16;
  localparam int COOL_TICKS = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_tick = 1'b0;
  logic [9:0] h_enemy = '0, v_enemy = '0;
  logic       enemy_valid = 1'b0;
  logic [9:0] h_my_plane = '0, v_my_plane = '0;
  logic [9:0] h_bullet, v_bullet;
  logic       active, hit;

  enemy_bullet_ctrl #(
    .V_BOTTOM(V_BOTTOM), .STEP(STEP), .PLANE_W(PLANE_W),
    .PLANE_H(PLANE_H), .COOL_TICKS(COOL_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick),
    .h_enemy(h_enemy), .v_enemy(v_enemy), .enemy_valid(enemy_valid),
    .h_my_plane(h_my_plane), .v_my_plane(v_my_plane),
    .h_bullet(h_bullet), .v_bullet(v_bullet), .active(active), .hit(hit)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: mode 0 = waiting, 1 = bullet falling, 2 = recovering
  int   m_mode, m_h, m_v, m_cool, m_hit;
  int   eligible, fires;
  int   hit_count, hit_v, hit_active;
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_h = 0; m_v = 0; m_cool = 0; m_hit = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step();
    bit fire_now;
    bit in_box;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef ENEMY_BULLET_LFSR_EN
    fire_now = (m_lfsr % 16) == 0;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
    fire_now = 1'b1;
`endif
    m_hit = 0;
    if (m_mode == 0) begin
      m_h = int'(h_enemy);
      m_v = int'(v_enemy);
      if (move_tick && enemy_valid) begin
        eligible++;
        if (fire_now) begin
          fires++;
          m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      in_box = (m_h >= int'(h_my_plane)) && (m_h <= int'(h_my_plane) + PLANE_W - 1) &&
               (m_v >= int'(v_my_plane)) && (m_v <= int'(v_my_plane) + PLANE_H - 1);
      if (in_box) begin
        m_hit = 1; m_mode = 2; m_cool = 0;
      end else if (move_tick) begin
        if (m_v + STEP > V_BOTTOM) begin
          m_mode = 2; m_cool = 0;
        end else begin
          m_v = m_v + STEP;
        end
      end
    end else begin
      m_h = int'(h_enemy);
      m_v = int'(v_enemy);
      if (move_tick) begin
        m_cool++;
        if (m_cool == COOL_TICKS) m_mode = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("h_bullet", 32'(h_bullet), 32'(m_h));
    chk("v_bullet", 32'(v_bullet), 32'(m_v));
    chk("active", 32'(active), 32'(m_mode == 1));
    chk("hit", 32'(hit), 32'(m_hit));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (hit === 1'b1) begin
      hit_count++;
      hit_v = int'(v_bullet);
      hit_active = int'(active);
    end
  endtask

  task automatic tick();
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
    cycle();
  endtask

  initial begin
    int hits_before;
    model_reset();
    eligible = 0; fires = 0; hit_count = 0; hit_v = -1; hit_active = -1;

    // reset state
    rst = 1'b1;
    h_enemy = 10'd300; v_enemy = 10'd300; enemy_valid = 1'b1;
    cycle();
    cycle();
    chk("rst_h", 32'(h_bullet), 32'd0);
    chk("rst_v", 32'(v_bullet), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    rst = 1'b0;

`ifndef ENEMY_BULLET_LFSR_EN
    // no shooter: bullet never leaves, position tracks the muzzle
    enemy_valid = 1'b0;
    h_my_plane = 10'd600; v_my_plane = 10'd0;
    for (int i = 0; i < 10; i++) begin
      h_enemy = 10'($urandom_range(0, 1023));
      v_enemy = 10'($urandom_range(0, 479));
      tick();
      chk("novalid_active", 32'(active), 32'd0);
      chk("novalid_h", 32'(h_bullet), 32'(h_enemy));
      chk("novalid_v", 32'(v_bullet), 32'(v_enemy));
    end

    // fire from (100,40) then fall three steps
    enemy_valid = 1'b1; h_enemy = 10'd100; v_enemy = 10'd40;
    tick();
    chk("fire_active", 32'(active), 32'd1);
    chk("fire_h", 32'(h_bullet), 32'd100);
    chk("fire_v", 32'(v_bullet), 32'd40);
    h_enemy = 10'd7; v_enemy = 10'd9;
    for (int i = 0; i < 3; i++) tick();
    chk("fall_v46", 32'(v_bullet), 32'd46);
    chk("fall_h100", 32'(h_bullet), 32'd100);

    // player at (90,200): single hit pulse when bullet reaches line 200
    h_my_plane = 10'd90; v_my_plane = 10'd200;
    hit_count = 0;
    for (int i = 0; i < 150 && hit_count == 0; i++) begin
      move_tick = 1'b1;
      cycle();
      move_tick = 1'b0;
      cycle();
      cycle();
    end
    for (int i = 0; i < 4; i++) cycle();
    chk("hit_count", 32'(hit_count), 32'd1);
    chk("hit_at_v200", 32'(hit_v), 32'd200);
    chk("hit_active0", 32'(hit_active), 32'd0);

    // cooldown back to idle
    h_my_plane = 10'd600; v_my_plane = 10'd0;
    for (int i = 0; i < COOL_TICKS; i++) tick();
    chk("cool_done_active", 32'(active), 32'd0);

    // bottom retire from line 478, then exactly COOL_TICKS ticks of cooldown
    h_enemy = 10'd100; v_enemy = 10'd478;
    tick();
    chk("fire478_active", 32'(active), 32'd1);
    hits_before = hit_count;
    tick();
    chk("bottom_active", 32'(active), 32'd0);
    chk("bottom_nohit", 32'(hit_count), 32'(hits_before));
    for (int i = 0; i < COOL_TICKS; i++) begin
      tick();
      chk("cool_no_fire", 32'(active), 32'd0);
    end
    tick();
    chk("refire_after_cool", 32'(active), 32'd1);

    // hit and bottom on the same cycle: the hit wins
    h_my_plane = 10'd90; v_my_plane = 10'd470;
    move_tick = 1'b1;
    cycle();
    move_tick = 1'b0;
    chk("hit_vs_bottom_hit", 32'(hit), 32'd1);
    chk("hit_vs_bottom_v", 32'(v_bullet), 32'd478);
    h_my_plane = 10'd600; v_my_plane = 10'd0;
    for (int i = 0; i < COOL_TICKS; i++) tick();

    // asynchronous reset in mid-flight
    v_enemy = 10'd40;
    tick();
    tick();
    tick();
    chk("pre_rst_active", 32'(active), 32'd1);
    hits_before = hit_count;
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_no_hit", 32'(hit_count), 32'(hits_before));
`endif

    // randomized traffic against the model
    eligible = 0; fires = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      enemy_valid = ($urandom_range(0, 7) != 0);
      h_enemy = 10'($urandom_range(0, 900));
      v_enemy = 10'($urandom_range(0, 479));
`ifdef ENEMY_BULLET_LFSR_EN
      h_my_plane = 10'd1000; v_my_plane = 10'd1000;
`else
      if ($urandom_range(0, 15) == 0) begin
        h_my_plane = 10'($urandom_range(0, 1023));
        v_my_plane = 10'($urandom_range(0, 1023));
      end
`endif
      move_tick = 1'b1;
      cycle();
      move_tick = 1'b0;
      for (int k = $urandom_range(0, 3); k > 0; k--) cycle();
    end
`ifdef ENEMY_BULLET_LFSR_EN
    chk("lfsr_fire_min", 32'(fires * 40 >= eligible), 32'd1);
    chk("lfsr_fire_max", 32'(fires * 6 <= eligible), 32'd1);
`else
    chk("rand_fires_eq_eligible", 32'(fires), 32'(eligible));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_ctrl.md
ENEMY_BULLET_CTRL -- requirements
Module: enemy_bullet_ctrl

Interface
REQ-001 Parameter V_BOTTOM, default 479, last visible line; bullet retires past it.
REQ-002 Parameter STEP, default 2, pixels moved down per move_tick.
REQ-003 Parameter PLANE_W, default 32, player hitbox width in pixels.
REQ-004 Parameter PLANE_H, default 16, player hitbox height in pixels.
REQ-005 Parameter COOL_TICKS, default 30, move_ticks spent in COOLDOWN.
REQ-006 clk  input  1  clock; reset rst, asynchronous, active-high.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 move_tick  input  1  single-cycle motion strobe, one per frame.
REQ-009 h_enemy, v_enemy  input  10 each  muzzle position of the selected shooter.
REQ-010 enemy_valid  input  1  selected shooter alive; firing is allowed only when high.
REQ-011 h_my_plane, v_my_plane  input  10 each  player top-left corner.
REQ-012 h_bullet, v_bullet  output  10 each  registered bullet position.
REQ-013 active  output  1  high while in FLY.
REQ-014 hit  output  1  one-cycle pulse on player hit.

Function
REQ-015 FSM states: IDLE, FLY, COOLDOWN; all outputs registered on posedge clk.
REQ-016 IDLE: h_bullet/v_bullet follow h_enemy/v_enemy every cycle; active=0.
REQ-017 IDLE -> FLY on a cycle with move_tick=1, enemy_valid=1 and the fire condition (REQ-027/028) true; position latches the muzzle value of that cycle.
REQ-018 FLY: on each move_tick, v_bullet <= v_bullet+STEP; h_bullet holds.
REQ-019 FLY hit test: every cycle, on registered position; hit when h_my_plane <= h_bullet <= h_my_plane+PLANE_W-1 and v_my_plane <= v_bullet <= v_my_plane+PLANE_H-1; bounds computed 11 bits wide, no wrap.
REQ-020 On hit: hit=1 for exactly the next cycle, FSM -> COOLDOWN, no further movement.
REQ-021 Bottom: in FLY, on move_tick with v_bullet+STEP > V_BOTTOM (11-bit sum), -> COOLDOWN without moving; hit stays 0.
REQ-022 Same cycle hit and bottom condition: hit wins (pulse issued), -> COOLDOWN.
REQ-023 enemy_valid dropping during FLY does not abort the bullet.
REQ-024 COOLDOWN: counter cleared on entry, increments per move_tick; -> IDLE when it reaches COOL_TICKS; position tracks muzzle as in IDLE.
REQ-025 Only one bullet in flight; fire conditions in FLY/COOLDOWN are ignored.

Reset
REQ-026 rst asynchronously forces IDLE, h_bullet=0, v_bullet=0, active=0, hit=0, cooldown counter=0, LFSR=16'hACE1; mid-flight reset abandons the bullet with no hit pulse.

Configuration
REQ-027 Macro ENEMY_BULLET_LFSR_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every clk; fire condition is LFSR[3:0]==4'h0.
REQ-028 Macro undefined: no LFSR; fire condition is constant true (fires on first eligible move_tick in IDLE).

Verification
REQ-029 Macro off, enemy (100,40) valid, one move_tick -> next cycle active=1, h_bullet=100, v_bullet=40; after 3 more ticks v_bullet=46.
REQ-030 Player at (90,200), bullet h=100 flying down -> hit pulses once when v_bullet reaches 200, active=0 next cycle, v_bullet frozen.
REQ-031 Player away, bullet v=478, STEP=2, move_tick -> COOLDOWN, hit=0; IDLE after exactly 30 more move_ticks.
REQ-032 enemy_valid=0 in IDLE with 10 move_ticks -> stays IDLE, positions track enemy inputs.
REQ-033 rst asserted mid-FLY between clock edges -> outputs 0, IDLE immediately, no hit pulse.
REQ-034 Macro on, 2000 move_ticks, never hit -> each fire coincides with LFSR[3:0]==0 vs reference model; about 1 in 16 eligible ticks fires.
